reg_wb_arbiter: RTL and testbench

- Write-back arbiter that owns the single register-file write port (we / w_addr / w_data) and merges two result sources into it.
- The in-order pipeline write-back has fixed priority and is always accepted. Results from the multi-cycle mul/div unit (MDU) arrive over a valid/ready handshake and are queued in a small FIFO.
- Queued MDU results drain into idle write-back slots.
- A lookup port reports the newest pending value of any register so decode can forward it or stall on it.

---
 rtl/reg_wb_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_reg_wb_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_arbiter.sv
// Register-file write-back arbiter: pipeline results win the write port, MDU results queue
// in a FIFO and drain into idle slots. Define WB_BYPASS_EN for same-cycle pipe forwarding.

module reg_wb_arbiter_chk (
  input logic clk,
  input logic rst,
  input logic pipe_we,
  input logic pipe_stall
);

  a_no_write_while_stalled : assert property (
    @(posedge clk) disable iff (rst) !(pipe_we && pipe_stall)
  ) else $error("reg_wb_arbiter: pipe_we asserted while pipe_stall is set");

endmodule

module reg_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_we,
  input  logic [4:0]               pipe_addr,
  input  logic [31:0]              pipe_data,
  output logic                     pipe_stall,
  input  logic                     mdu_valid,
  output logic                     mdu_ready,
  input  logic [4:0]               mdu_addr,
  input  logic [31:0]              mdu_data,
  output logic                     rf_we,
  output logic [4:0]               rf_addr,
  output logic [31:0]              rf_data,
  input  logic [4:0]               fwd_addr,
  output logic                     fwd_hit,
  output logic [31:0]              fwd_data,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [7:0]    LIMIT_C = 8'(STARVE_LIMIT);

  logic [4:0]    mem_addr_r [DEPTH];
  logic [31:0]   mem_data_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic [7:0]    starve_r;
  logic [7:0]    starve_nxt_s;
  logic          stall_r;
  logic          stall_nxt_s;
  logic          rf_we_r;
  logic [4:0]    rf_addr_r;
  logic [31:0]   rf_data_r;
  logic          empty_s;
  logic          full_s;
  logic          pipe_win_s;
  logic          push_s;
  logic          pop_s;
  logic          match_s;
  logic          fifo_hit_s;
  logic [31:0]   fifo_data_s;

  assign empty_s    = (count_r == {CW{1'b0}});
  assign full_s     = (count_r == CNT_FULL);
  assign pipe_win_s = pipe_we && (pipe_addr != 5'd0);
  // x0 handshakes complete but leave nothing behind
  assign push_s     = mdu_valid && !full_s && (mdu_addr != 5'd0);
  assign pop_s      = !pipe_win_s && !empty_s;

  assign mdu_ready  = !full_s;
  assign pending    = count_r;
  assign pipe_stall = stall_r;
  assign rf_we      = rf_we_r;
  assign rf_addr    = rf_addr_r;
  assign rf_data    = rf_data_r;

  // FIFO occupancy next-state
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r <= count_nxt_s;
    end
  end

  // FIFO storage; entries beyond the occupancy are never read
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_addr_r[wr_ptr_r] <= mdu_addr;
      mem_data_r[wr_ptr_r] <= mdu_data;
    end
  end

  // Registered write port: pipe first, then FIFO head, else idle holding address/data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_r   <= 1'b0;
      rf_addr_r <= 5'd0;
      rf_data_r <= 32'd0;
    end else if (pipe_win_s) begin
      rf_we_r   <= 1'b1;
      rf_addr_r <= pipe_addr;
      rf_data_r <= pipe_data;
    end else if (pop_s) begin
      rf_we_r   <= 1'b1;
      rf_addr_r <= mem_addr_r[rd_ptr_r];
      rf_data_r <= mem_data_r[rd_ptr_r];
    end else begin
      rf_we_r   <= 1'b0;
    end
  end

  // Starvation counter saturates at the limit; stall holds until the FIFO is seen empty
  always_comb begin
    starve_nxt_s = starve_r;
    stall_nxt_s  = stall_r;
    if (empty_s || pop_s) begin
      starve_nxt_s = 8'd0;
    end else if (starve_r < LIMIT_C) begin
      starve_nxt_s = starve_r + 8'd1;
    end else begin
      starve_nxt_s = starve_r;
    end
    if (empty_s) begin
      stall_nxt_s = 1'b0;
    end else if (starve_r == LIMIT_C) begin
      stall_nxt_s = 1'b1;
    end else begin
      stall_nxt_s = stall_r;
    end
  end

  // Starvation state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_r <= 8'd0;
      stall_r  <= 1'b0;
    end else begin
      starve_r <= starve_nxt_s;
      stall_r  <= stall_nxt_s;
    end
  end

  // Youngest matching FIFO entry: scan oldest to youngest, later matches override
  always_comb begin
    fifo_hit_s  = 1'b0;
    fifo_data_s = 32'd0;
    match_s     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      match_s     = (CW'(i) < count_r) && (mem_addr_r[rd_ptr_r + AW'(i)] == fwd_addr);
      fifo_hit_s  = fifo_hit_s | match_s;
      fifo_data_s = match_s ? mem_data_r[rd_ptr_r + AW'(i)] : fifo_data_s;
    end
  end

  // Forward lookup priority select
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 32'd0;
    if (fwd_addr == 5'd0) begin
      fwd_hit  = 1'b0;
      fwd_data = 32'd0;
`ifdef WB_BYPASS_EN
    end else if (pipe_we && (pipe_addr == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = pipe_data;
`endif
    end else if (fifo_hit_s) begin
      fwd_hit  = 1'b1;
      fwd_data = fifo_data_s;
    end else if (rf_we_r && (rf_addr_r == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = rf_data_r;
    end else begin
      fwd_hit  = 1'b0;
      fwd_data = 32'd0;
    end
  end

  reg_wb_arbiter_chk u_chk (
    .clk        (clk),
    .rst        (rst),
    .pipe_we    (pipe_we),
    .pipe_stall (stall_r)
  );

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench for reg_wb_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based reference model; a negedge monitor pops expected register writes.

module tb_reg_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_addr = 5'd0;
  logic [31:0] pipe_data = 32'd0;
  logic        pipe_stall;
  logic        mdu_valid = 1'b0;
  logic        mdu_ready;
  logic [4:0]  mdu_addr = 5'd0;
  logic [31:0] mdu_data = 32'd0;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [4:0]  fwd_addr = 5'd0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [2:0]  pending;

  reg_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];     // model of queued MDU results, oldest first
  ent_t        exp_q[$];  // expected register-file writes, in order
  ent_t        mon_e;
  logic        last_we = 1'b0;
  logic [4:0]  last_addr = 5'd0;
  logic [31:0] last_data = 32'd0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic void model_fwd(input logic [4:0] fa, input logic pw, input logic [4:0] pa,
                                    input logic [31:0] pd, output logic hit, output logic [31:0] fd);
    logic byp;
    byp = 1'b0;
`ifdef WB_BYPASS_EN
    byp = 1'b1;
`endif
    hit = 1'b0;
    fd  = 32'd0;
    if (fa == 5'd0) return;
    if (byp && pw && pa == fa) begin
      hit = 1'b1; fd = pd; return;
    end
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].a == fa) begin
        hit = 1'b1; fd = mq[i].d; return;
      end
    end
    if (last_we && last_addr == fa) begin
      hit = 1'b1; fd = last_data;
    end
  endfunction

  // Monitor: every register-file write must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && rf_we) begin
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(rf_addr), 32'(mon_e.a));
        chk("wr_data", rf_data, mon_e.d);
      end
    end
  end

  // One cycle of stimulus; called just after a rising edge, returns just after the next one
  task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic [4:0] fa);
    logic        pw_e;
    logic        hit;
    logic [31:0] fd;
    ent_t        e;
    int          sz;
    chk("rf_we", 32'(rf_we), 32'(last_we));
    chk("rf_addr", 32'(rf_addr), 32'(last_addr));
    chk("rf_data", rf_data, last_data);
    pw_e      = pw && !pipe_stall;
    pipe_we   = pw_e;
    pipe_addr = pa;
    pipe_data = pd;
    mdu_valid = mv;
    mdu_addr  = ma;
    mdu_data  = md;
    fwd_addr  = fa;
    #1;
    chk("pending", 32'(pending), 32'(mq.size()));
    chk("mdu_ready", 32'(mdu_ready), 32'(mq.size() < DEPTH));
    model_fwd(fa, pw_e, pa, pd, hit, fd);
    chk("fwd_hit", 32'(fwd_hit), 32'(hit));
    chk("fwd_data", fwd_data, fd);
    sz = mq.size();
    if (pw_e && pa != 5'd0) begin
      e.a = pa; e.d = pd;
      exp_q.push_back(e);
      last_we = 1'b1; last_addr = pa; last_data = pd;
    end else if (sz > 0) begin
      e = mq.pop_front();
      exp_q.push_back(e);
      last_we = 1'b1; last_addr = e.a; last_data = e.d;
    end else begin
      last_we = 1'b0;
    end
    if (mv && sz < DEPTH && ma != 5'd0) begin
      e.a = ma; e.d = md;
      mq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [4:0] fa);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, fa);
  endtask

  initial begin
    int busy;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_rf_we", 32'(rf_we), 32'd0);
    chk("reset_rf_addr", 32'(rf_addr), 32'd0);
    chk("reset_rf_data", rf_data, 32'd0);
    chk("reset_pending", 32'(pending), 32'd0);
    chk("reset_stall", 32'(pipe_stall), 32'd0);
    chk("reset_mdu_ready", 32'(mdu_ready), 32'd1);

    // pipe only
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5);
    chk("pipe_only_we", 32'(rf_we), 32'd1);
    chk("pipe_only_addr", 32'(rf_addr), 32'd5);
    chk("pipe_only_data", rf_data, 32'hDEADBEEF);
    idle(5'd5);
    chk("pipe_only_we_low", 32'(rf_we), 32'd0);

    // x0 drop on both sources
    drive(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h5678, 5'd0);
    chk("x0_rf_we", 32'(rf_we), 32'd0);
    chk("x0_pending", 32'(pending), 32'd0);
    chk("x0_mdu_ready", 32'(mdu_ready), 32'd1);
    idle(5'd0);

    // queue four MDU results behind a busy pipe, then drain
    for (int i = 1; i <= 4; i++)
      drive(1'b1, 5'd9, 32'(i * 100), 1'b1, 5'(i), 32'(i * 16), 5'($urandom_range(0, 7)));
    chk("queue_full_ready", 32'(mdu_ready), 32'd0);
    chk("queue_full_pending", 32'(pending), 32'd4);
    for (int k = 0; k < 4; k++) begin
      idle(5'($urandom_range(0, 7)));
      chk("drain_we", 32'(rf_we), 32'd1);
      chk("drain_pending", 32'(pending), 32'(3 - k));
    end

    // starvation
    drive(1'b1, 5'd10, 32'hA0, 1'b1, 5'd3, 32'h33, 5'd0);
    chk("starve_stall_0", 32'(pipe_stall), 32'd0);
    for (int k = 1; k <= 9; k++) begin
      drive(1'b1, 5'd10, 32'(k), 1'b0, 5'd0, 32'd0, 5'd3);
      chk("starve_stall", 32'(pipe_stall), 32'(k >= 9));
    end
    idle(5'd3);
    chk("starve_head_we", 32'(rf_we), 32'd1);
    chk("starve_head_addr", 32'(rf_addr), 32'd3);
    chk("starve_head_data", rf_data, 32'h33);
    chk("starve_stall_held", 32'(pipe_stall), 32'd1);
    idle(5'd0);
    chk("starve_stall_clear", 32'(pipe_stall), 32'd0);

    // forward priority: FIFO {r7=1, r7=2}, rf r7=3
    drive(1'b1, 5'd11, 32'hB, 1'b1, 5'd7, 32'h1, 5'd0);
    drive(1'b1, 5'd7, 32'h3, 1'b1, 5'd7, 32'h2, 5'd0);
    pipe_we  = 1'b0;
    fwd_addr = 5'd7;
    #1;
    chk("fwd_prio_hit", 32'(fwd_hit), 32'd1);
    chk("fwd_prio_data", fwd_data, 32'h2);
    fwd_addr = 5'd0;
    #1;
    chk("fwd_x0_hit", 32'(fwd_hit), 32'd0);
    chk("fwd_x0_data", fwd_data, 32'd0);
    repeat (3) idle(5'd7);

    // asynchronous reset with three queued entries
    for (int i = 0; i < 3; i++)
      drive(1'b1, 5'd13, 32'(i), 1'b1, 5'(20 + i), 32'(32'hC0 + i), 5'd0);
    chk("pre_reset_pending", 32'(pending), 32'd3);
    #2;
    pipe_we = 1'b0; mdu_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_we", 32'(rf_we), 32'd0);
    chk("async_rst_pending", 32'(pending), 32'd0);
    chk("async_rst_ready", 32'(mdu_ready), 32'd1);
    mq.delete();
    exp_q.delete();
    last_we = 1'b0; last_addr = 5'd0; last_data = 32'd0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) idle(5'($urandom_range(20, 22)));

    // randomized traffic in phases of varying pipeline load
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) busy = $urandom_range(20, 95);
      drive(1'($urandom_range(0, 99) < busy), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 99) < 40), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)));
    end
    repeat (DEPTH + 2) idle(5'($urandom_range(0, 7)));
    @(negedge clk);
    #1;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
